// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one combinational ALU between
// NUM_REQ valid/ready requesters, with a one-entry tagged response register.
module alu_req_arbiter #(
  parameter int unsigned size    = 32,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [4*NUM_REQ-1:0]      req_op,
  input  logic [size*NUM_REQ-1:0]   req_a,
  input  logic [size*NUM_REQ-1:0]   req_b,
  output logic                      alu_reset,
  output logic [3:0]                alu_op,
  output logic [size-1:0]           alu_a,
  output logic [size-1:0]           alu_b,
  input  logic [size-1:0]           alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [size-1:0]           rsp_data,
  output logic                      rsp_err
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam logic [3:0]  OP_NOP = 4'b1111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [size-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              can_issue;
  logic              grant_found;
  logic              grant_en;
  logic [ID_W-1:0]   grant_id;
  logic              op_legal;

  assign alu_reset = ~Reset_n;
  assign can_issue = (state_q == EMPTY) | rsp_ready;
  // Gated by Reset_n so no handshake can complete while reset is asserted.
  assign grant_en  = Reset_n & can_issue & grant_found;

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    logic [ID_W:0] sum;
    logic [ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  // One-hot ready and operand mux for the granted requester; NOP when idle.
  always_comb begin
    req_ready = '0;
    alu_op    = OP_NOP;
    alu_a     = '0;
    alu_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_en && (grant_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        alu_op       = req_op[i*4 +: 4];
        alu_a        = req_a[i*size +: size];
        alu_b        = req_b[i*size +: size];
      end
    end
  end

  // Illegal opcode range 1000..1100.
  assign op_legal = !((alu_op >= 4'd8) && (alu_op <= 4'd12));

  // Response buffer next-state: capture on accept, drain when consumed.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      EMPTY: begin
        if (grant_en) state_d = FULL;
      end
      FULL: begin
        if (!grant_en && rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (grant_en) begin
      rr_ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      rsp_id_d   = grant_id;
      rsp_err_d  = ~op_legal;
      rsp_data_d = op_legal ? alu_result : '0;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus a randomized run
// against a queue-free transaction-level reference model.
module tb_alu_req_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic            clk;
  logic            Reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_op;
  logic [W*N-1:0]  req_a;
  logic [W*N-1:0]  req_b;
  logic            alu_reset;
  logic [3:0]      alu_op;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [W-1:0]    alu_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_err;

  int checks;
  int failures;

  // Reference model state
  bit        m_valid;
  int        m_id;
  logic [W-1:0] m_data;
  bit        m_err;
  int        m_ptr;

  alu_req_arbiter #(.size(W), .NUM_REQ(N)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_reset(alu_reset), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; illegal codes return garbage so the zeroing is visible.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd13: return ~(a | b);
      4'd14: return a;
      4'd15: return '0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  function automatic int model_grant();
    if (!Reset_n) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_data = '0; m_err = 0; m_ptr = 0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]      = v;
    req_op[i*4 +: 4]  = op;
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
  endtask

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic tick();
    int g;
    logic [3:0] op;
    logic [W-1:0] a, b;
    g = model_grant();
    if (!Reset_n) begin
      model_reset();
    end else if (g >= 0) begin
      op = req_op[g*4 +: 4];
      a  = req_a[g*W +: W];
      b  = req_b[g*W +: W];
      m_err   = (op >= 4'd8) && (op <= 4'd12);
      m_data  = m_err ? '0 : alu_fn(op, a, b);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b id=%0d d=%h e=%b, want 0 0 0 0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    checks++;
    if (alu_reset !== 1'b1 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got alu_reset=%b req_ready=%b, want 1 0000", alu_reset, req_ready);
    end
    Reset_n = 1'b1;
    tick();
    checks++;
    if (alu_reset !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got alu_reset=%b want 0", alu_reset);
    end
  endtask

  task automatic test_round_robin();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'b0001, 32'd10, 32'd3);
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] exp_rdy;
      logic [1:0] exp_id;
      exp_rdy = 4'b0001 << (k % N);
      exp_id  = 2'((k + N - 1) % N);
      @(negedge clk);
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy);
      end
      if (k > 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== 32'd7) begin
          failures++;
          $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%0d want 1 %0d 7", k, rsp_valid, rsp_id, rsp_data, exp_id);
        end
      end
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'd7) begin
      failures++;
      $display("FAIL rr_last: got v=%b id=%0d d=%0d want 1 0 7", rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_single_op();
    rsp_ready = 1'b1;
    req_valid = '0;
    set_req(2, 1'b1, 4'b0000, 32'd5, 32'd7);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100 || alu_op !== 4'b0000 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      failures++;
      $display("FAIL single_accept: got rdy=%b op=%b a=%0d b=%0d want 0100 0000 5 7",
               req_ready, alu_op, alu_a, alu_b);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'd12 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got v=%b id=%0d d=%0d e=%b want 1 2 12 0", rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    rsp_ready = 1'b0;
    req_valid = '0;
    set_req(0, 1'b1, 4'b0000, 32'd1, 32'd2);
    tick();
    set_req(0, 1'b1, 4'b0000, 32'd100, 32'd1);
    set_req(3, 1'b1, 4'b0000, 32'd40, 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'd3) begin
        failures++;
        $display("FAIL bp_stall[%0d]: got rdy=%b v=%b id=%0d d=%0d want 0000 1 0 3",
                 k, req_ready, rsp_valid, rsp_id, rsp_data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b want 1000", req_ready);
    end
    tick();
    req_valid[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 32'd42) begin
      failures++;
      $display("FAIL bp_replace: got v=%b id=%0d d=%0d want 1 3 42", rsp_valid, rsp_id, rsp_data);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_illegal_op();
    rsp_ready = 1'b1;
    req_valid = '0;
    set_req(1, 1'b1, 4'b1010, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL illegal_accept: got rdy=%b want 0010", req_ready);
    end
    tick();
    set_req(1, 1'b1, 4'b0000, 32'd2, 32'd3);
    @(negedge clk);
    checks++;
    if (rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL illegal_rsp: got e=%b d=%h id=%0d v=%b want 1 0 1 1", rsp_err, rsp_data, rsp_id, rsp_valid);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_err !== 1'b0 || rsp_data !== 32'd5 || rsp_id !== 2'd1) begin
      failures++;
      $display("FAIL illegal_clear: got e=%b d=%0d id=%0d want 0 5 1", rsp_err, rsp_data, rsp_id);
    end
  endtask

  task automatic test_idle();
    rsp_ready = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (alu_op !== 4'b1111 || alu_a !== '0 || alu_b !== '0 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL idle_nop: got op=%b a=%h b=%h v=%b want 1111 0 0 1", alu_op, alu_a, alu_b, rsp_valid);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd1 || rsp_data !== 32'd5) begin
      failures++;
      $display("FAIL idle_drain: got v=%b id=%0d d=%0d want 0 1 5", rsp_valid, rsp_id, rsp_data);
    end
    tick();
    tick();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'b0100, 32'hF0, 32'h0F);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL idle_ptr_hold: got rdy=%b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    set_req(3, 1'b1, 4'b0000, 32'd9, 32'd9);
    tick();
    @(negedge clk);
    Reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || alu_reset !== 1'b1 || rsp_data !== '0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b rdy=%b alu_reset=%b d=%h want 0 0000 1 0",
               rsp_valid, req_ready, alu_reset, rsp_data);
    end
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'b0000, 32'd1, 32'd1);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ptr: got rdy=%b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [N-1:0] exp_rdy;
      logic [3:0] exp_op;
      logic [W-1:0] exp_a, exp_b;
      for (int i = 0; i < N; i++) begin
        // Hold payloads of requests still waiting, as requesters must.
        if (!(req_valid[i] && !req_ready[i]) || ($urandom_range(0, 7) == 0))
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = model_grant();
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      exp_op  = (g >= 0) ? req_op[g*4 +: 4] : 4'b1111;
      exp_a   = (g >= 0) ? req_a[g*W +: W] : '0;
      exp_b   = (g >= 0) ? req_b[g*W +: W] : '0;
      checks++;
      if (req_ready !== exp_rdy || alu_op !== exp_op || alu_a !== exp_a || alu_b !== exp_b) begin
        failures++;
        $display("FAIL rand_grant[%0d]: got rdy=%b op=%b a=%h b=%h want %b %b %h %h",
                 c, req_ready, alu_op, alu_a, alu_b, exp_rdy, exp_op, exp_a, exp_b);
      end
      checks++;
      if (rsp_valid !== m_valid || rsp_id !== 2'(m_id) || rsp_data !== m_data || rsp_err !== m_err) begin
        failures++;
        $display("FAIL rand_rsp[%0d]: got v=%b id=%0d d=%h e=%b want %b %0d %h %b",
                 c, rsp_valid, rsp_id, rsp_data, rsp_err, m_valid, m_id, m_data, m_err);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Reset_n = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_single_op();
    test_back_pressure();
    test_illegal_op();
    test_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
